timer0_peripheral: RTL and testbench

TIMER0_PERIPHERAL -- requirements
Module: timer0_peripheral

---
 rtl/timer0_peripheral.sv | 121 ++++++++++++
 tb/tb_timer0_peripheral.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer0_peripheral.sv
// TMR0 timer/counter with OPTION_REG, shared 8-bit prescaler, pin synchroniser
// and the two-instruction-cycle write inhibit.
module timer0_peripheral (
    input  logic       clk,
    input  logic       rst,
    input  logic       cycle_en,
    input  logic [8:0] extern_peripherals_addr,
    input  logic [7:0] extern_peripherals_data_in,
    input  logic       extern_peripherals_wr_en,
    output logic [7:0] extern_peripherals_data_out,
    output logic       extern_peripherals_hit,
    input  logic       t0cki,
    output logic       t0if_set,
    output logic [7:0] tmr0_value
);

    logic [7:0] tmr0;
    logic [7:0] option;
    logic [7:0] prescaler;
    logic [1:0] inhibit;
    logic       sync_p0, sync_p1, sync_p2;

    logic tmr0_hit, option_hit, tmr0_wr, option_wr;
    logic t0cs, t0se, psa;
    logic [2:0] ps;
    logic pin_rise, pin_fall;
    logic src_evt, pre_wrap, inc_evt, inc_ok;

    // Wrap point 2^(PS+1)-1 is a right-aligned mask of PS+1 ones.
    function automatic logic [7:0] prescale_limit(input logic [2:0] sel);
        prescale_limit = 8'hFF >> (3'd7 - sel);
    endfunction

    // Bank bit 7 separates TMR0 (banks 0/2) from OPTION_REG (banks 1/3).
    assign tmr0_hit   = (extern_peripherals_addr[6:0] == 7'h01) && !extern_peripherals_addr[7];
    assign option_hit = (extern_peripherals_addr[6:0] == 7'h01) &&  extern_peripherals_addr[7];
    assign extern_peripherals_hit = tmr0_hit | option_hit;
    assign tmr0_wr   = extern_peripherals_wr_en & tmr0_hit;
    assign option_wr = extern_peripherals_wr_en & option_hit;

    always_comb begin
        extern_peripherals_data_out = 8'h00;
        if (tmr0_hit)
            extern_peripherals_data_out = tmr0;
        else if (option_hit)
            extern_peripherals_data_out = option;
    end

    assign t0cs = option[5];
    assign t0se = option[4];
    assign psa  = option[3];
    assign ps   = option[2:0];

    // sync_p0/p1 resynchronise the pin, sync_p2 holds the previous level for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= t0cki;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign pin_rise = sync_p1 & ~sync_p2;
    assign pin_fall = ~sync_p1 & sync_p2;

    always_comb begin
        src_evt = cycle_en;
        if (t0cs)
            src_evt = t0se ? pin_fall : pin_rise;
    end

    assign pre_wrap = (prescaler == prescale_limit(ps));
    assign inc_evt  = src_evt & (psa | pre_wrap);
    assign inc_ok   = inc_evt & (inhibit == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            option <= 8'hFF;
        else if (option_wr)
            option <= extern_peripherals_data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prescaler <= 8'h00;
        else if (tmr0_wr || option_wr || psa)
            prescaler <= 8'h00;
        else if (src_evt)
            prescaler <= pre_wrap ? 8'h00 : prescaler + 8'd1;
    end

    // Inhibit still counts instruction cycles, whatever the clock source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            inhibit <= 2'd0;
        else if (tmr0_wr)
            inhibit <= 2'd2;
        else if (cycle_en && inhibit != 2'd0)
            inhibit <= inhibit - 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr0     <= 8'h00;
            t0if_set <= 1'b0;
        end else begin
            t0if_set <= inc_ok & ~tmr0_wr & (tmr0 == 8'hFF);
            if (tmr0_wr)
                tmr0 <= extern_peripherals_data_in;
            else if (inc_ok)
                tmr0 <= tmr0 + 8'd1;
        end
    end

    assign tmr0_value = tmr0;

endmodule

// File: tb/tb_timer0_peripheral.sv
// Randomised and directed bench for timer0_peripheral against a cycle-level
// behavioural model of the timer rules.
module tb_timer0_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       cycle_en;
    logic [8:0] addr;
    logic [7:0] data_in;
    logic       wr_en;
    logic [7:0] data_out;
    logic       hit;
    logic       t0cki;
    logic       t0if_set;
    logic [7:0] tmr0_value;

    always #5 clk = ~clk;

    timer0_peripheral dut (
        .clk                         (clk),
        .rst                         (rst),
        .cycle_en                    (cycle_en),
        .extern_peripherals_addr     (addr),
        .extern_peripherals_data_in  (data_in),
        .extern_peripherals_wr_en    (wr_en),
        .extern_peripherals_data_out (data_out),
        .extern_peripherals_hit      (hit),
        .t0cki                       (t0cki),
        .t0if_set                    (t0if_set),
        .tmr0_value                  (tmr0_value)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int if_pulses = 0;

    // Reference state
    logic [7:0] m_tmr;
    logic [7:0] m_opt;
    logic [7:0] m_pre;
    int         m_inh;
    logic       m_if;
    logic [2:0] m_hist;

    function automatic logic model_hit(input logic [8:0] a);
        return (a == 9'h001 || a == 9'h101 || a == 9'h081 || a == 9'h181);
    endfunction

    function automatic logic [7:0] model_read(input logic [8:0] a);
        if (a == 9'h001 || a == 9'h101) return m_tmr;
        if (a == 9'h081 || a == 9'h181) return m_opt;
        return 8'h00;
    endfunction

    function automatic void model_reset();
        m_tmr  = 8'h00;
        m_opt  = 8'hFF;
        m_pre  = 8'h00;
        m_inh  = 0;
        m_if   = 1'b0;
        m_hist = 3'b000;
    endfunction

    // One rising clock edge of the reference, using the inputs currently driven.
    function automatic void model_edge();
        logic src;
        logic inc;
        int   ratio;
        logic tmr_hit;
        logic opt_hit;
        tmr_hit = (addr == 9'h001 || addr == 9'h101);
        opt_hit = (addr == 9'h081 || addr == 9'h181);
        m_if = 1'b0;
        // synchronised pin = sample two edges back, previous = three edges back
        if (m_opt[5])
            src = m_opt[4] ? (!m_hist[1] && m_hist[2]) : (m_hist[1] && !m_hist[2]);
        else
            src = cycle_en;
        inc = 1'b0;
        if (m_opt[3]) begin
            inc   = src;
            m_pre = 8'h00;
        end else if (src) begin
            ratio = 1 << (int'(m_opt[2:0]) + 1);
            if (int'(m_pre) + 1 == ratio) begin
                m_pre = 8'h00;
                inc   = 1'b1;
            end else begin
                m_pre = m_pre + 8'd1;
            end
        end
        if (wr_en && tmr_hit) begin
            m_tmr = data_in;
            m_pre = 8'h00;
            m_inh = 2;
        end else begin
            if (inc && m_inh == 0) begin
                m_if  = (m_tmr == 8'hFF);
                m_tmr = 8'((int'(m_tmr) + 1) % 256);
            end
            if (cycle_en && m_inh > 0) m_inh = m_inh - 1;
        end
        if (wr_en && opt_hit) begin
            m_opt = data_in;
            m_pre = 8'h00;
        end
        m_hist = {m_hist[1:0], t0cki};
    endfunction

    task automatic step(input logic cen, input logic [8:0] a, input logic [7:0] d,
                        input logic w, input logic t);
        cycle_en = cen;
        addr     = a;
        data_in  = d;
        wr_en    = w;
        t0cki    = t;
        model_edge();
        @(posedge clk);
        #1;
        if (t0if_set === 1'b1) if_pulses++;
        cycle_en = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, addr, 8'h00, 1'b0, t0cki);
    endtask

    task automatic tick();
        step(1'b1, addr, 8'h00, 1'b0, t0cki);
        idle(3);
    endtask

    task automatic wr_reg(input logic [8:0] a, input logic [7:0] d);
        step(1'b0, a, d, 1'b1, t0cki);
    endtask

    task automatic test_reset();
        rst = 1'b0; cycle_en = 1'b0; wr_en = 1'b0; data_in = 8'h00; t0cki = 1'b0;
        addr = 9'h001;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (tmr0_value !== 8'h00) $display("FAIL reset_tmr0 got=%h want=%h", tmr0_value, 8'h00);
        else n_pass++;
        n_checks++;
        if (data_out !== 8'h00 || hit !== 1'b1)
            $display("FAIL reset_read_tmr0 got=%h/%b want=00/1", data_out, hit);
        else n_pass++;
        n_checks++;
        if (t0if_set !== 1'b0) $display("FAIL reset_t0if got=%b want=0", t0if_set);
        else n_pass++;
        addr = 9'h081;
        #1;
        n_checks++;
        if (data_out !== 8'hFF) $display("FAIL reset_read_option got=%h want=%h", data_out, 8'hFF);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_seq [5] = '{8'hFD, 8'hFD, 8'hFE, 8'hFF, 8'h00};
        wr_reg(9'h081, 8'h08);
        wr_reg(9'h001, 8'hFD);
        if_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, addr, 8'h00, 1'b0, t0cki);
            n_checks++;
            if (tmr0_value !== exp_seq[i])
                $display("FAIL overflow_tick%0d got=%h want=%h", i, tmr0_value, exp_seq[i]);
            else n_pass++;
            n_checks++;
            if (t0if_set !== (i == 4))
                $display("FAIL overflow_t0if%0d got=%b want=%b", i, t0if_set, (i == 4));
            else n_pass++;
            idle(3);
        end
        n_checks++;
        if (if_pulses != 1) $display("FAIL overflow_pulse_count got=%0d want=1", if_pulses);
        else n_pass++;
    endtask

    task automatic test_prescale();
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        wr_reg(9'h081, 8'h02);
        wr_reg(9'h001, r);
        tick();
        tick();
        n_checks++;
        if (tmr0_value !== r) $display("FAIL prescale_inhibit got=%h want=%h", tmr0_value, r);
        else n_pass++;
        for (int i = 0; i < 24; i++) tick();
        n_checks++;
        if (tmr0_value !== 8'(r + 8'd3)) $display("FAIL prescale_advance got=%h want=%h", tmr0_value, 8'(r + 8'd3));
        else n_pass++;
        n_checks++;
        if (tmr0_value !== m_tmr) $display("FAIL prescale_model got=%h want=%h", tmr0_value, m_tmr);
        else n_pass++;
    endtask

    task automatic test_external();
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        wr_reg(9'h081, 8'h38);
        wr_reg(9'h001, r);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, addr, 8'h00, 1'b0, 1'b1);
            idle(3);
            step(1'b0, addr, 8'h00, 1'b0, 1'b0);
            idle(3);
        end
        n_checks++;
        if (tmr0_value !== 8'(r + 8'd4)) $display("FAIL ext_fall got=%h want=%h", tmr0_value, 8'(r + 8'd4));
        else n_pass++;
        n_checks++;
        if (tmr0_value !== m_tmr) $display("FAIL ext_model got=%h want=%h", tmr0_value, m_tmr);
        else n_pass++;
        step(1'b0, addr, 8'h00, 1'b0, 1'b1);
        idle(5);
        n_checks++;
        if (tmr0_value !== 8'(r + 8'd4)) $display("FAIL ext_rise_only got=%h want=%h", tmr0_value, 8'(r + 8'd4));
        else n_pass++;
    endtask

    task automatic test_write_priority();
        wr_reg(9'h081, 8'h08);
        wr_reg(9'h001, 8'hFF);
        tick();
        tick();
        n_checks++;
        if (tmr0_value !== 8'hFF) $display("FAIL prio_pre got=%h want=%h", tmr0_value, 8'hFF);
        else n_pass++;
        step(1'b1, 9'h001, 8'h10, 1'b1, t0cki);
        n_checks++;
        if (tmr0_value !== 8'h10) $display("FAIL prio_value got=%h want=%h", tmr0_value, 8'h10);
        else n_pass++;
        n_checks++;
        if (t0if_set !== 1'b0) $display("FAIL prio_t0if got=%b want=0", t0if_set);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_decode();
        logic [7:0] old_tmr;
        logic [7:0] old_opt;
        logic [8:0] a;
        step(1'b0, 9'h101, 8'h00, 1'b0, t0cki);
        n_checks++;
        if (data_out !== m_tmr || hit !== 1'b1)
            $display("FAIL decode_101 got=%h/%b want=%h/1", data_out, hit, m_tmr);
        else n_pass++;
        step(1'b0, 9'h181, 8'h00, 1'b0, t0cki);
        n_checks++;
        if (data_out !== 8'h08 || hit !== 1'b1)
            $display("FAIL decode_181 got=%h/%b want=08/1", data_out, hit);
        else n_pass++;
        old_tmr = m_tmr;
        old_opt = m_opt;
        step(1'b0, 9'h002, 8'($urandom_range(0, 255)), 1'b1, t0cki);
        n_checks++;
        if (data_out !== 8'h00 || hit !== 1'b0)
            $display("FAIL decode_002 got=%h/%b want=00/0", data_out, hit);
        else n_pass++;
        n_checks++;
        if (tmr0_value !== old_tmr) $display("FAIL decode_nohit_write got=%h want=%h", tmr0_value, old_tmr);
        else n_pass++;
        step(1'b0, 9'h081, 8'h00, 1'b0, t0cki);
        n_checks++;
        if (data_out !== old_opt) $display("FAIL decode_option_kept got=%h want=%h", data_out, old_opt);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            a = 9'($urandom_range(0, 511));
            step(1'b0, a, 8'h00, 1'b0, t0cki);
            n_checks++;
            if (data_out !== model_read(a) || hit !== model_hit(a))
                $display("FAIL decode_rand addr=%h got=%h/%b want=%h/%b",
                         a, data_out, hit, model_read(a), model_hit(a));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [8:0] addr_tab [6] = '{9'h001, 9'h101, 9'h081, 9'h181, 9'h002, 9'h000};
        logic [8:0] a;
        logic       w;
        logic       t;
        for (int i = 0; i < 400; i++) begin
            a = addr_tab[$urandom_range(0, 5)];
            if (a == 9'h000) a = 9'($urandom_range(0, 511));
            w = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 4) == 0) ? ~t0cki : t0cki;
            step((i % 4) == 0, a, 8'($urandom_range(0, 255)), w, t);
            n_checks++;
            if (tmr0_value !== m_tmr || t0if_set !== m_if || data_out !== model_read(a))
                $display("FAIL random_cyc%0d got=%h/%b/%h want=%h/%b/%h", i,
                         tmr0_value, t0if_set, data_out, m_tmr, m_if, model_read(a));
            else n_pass++;
        end
    endtask

    task automatic test_reset_midprescale();
        wr_reg(9'h081, 8'h02);
        wr_reg(9'h001, 8'h40);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (tmr0_value !== 8'h00 || t0if_set !== 1'b0)
            $display("FAIL midreset_tmr0 got=%h/%b want=00/0", tmr0_value, t0if_set);
        else n_pass++;
        addr = 9'h181;
        #1;
        n_checks++;
        if (data_out !== 8'hFF) $display("FAIL midreset_option got=%h want=%h", data_out, 8'hFF);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (tmr0_value !== 8'h00) $display("FAIL midreset_no_count got=%h want=00", tmr0_value);
        else n_pass++;
        wr_reg(9'h081, 8'h08);
        tick();
        n_checks++;
        if (tmr0_value !== 8'h01) $display("FAIL midreset_first_inc got=%h want=01", tmr0_value);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_prescale();
        test_external();
        test_write_priority();
        test_decode();
        test_random();
        test_reset_midprescale();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
